// File: rtl/sat_restore.sv
// Colour-restore stage: scales HSV saturation by a gain that ramps between 0
// and unity in frame-synchronous steps, fading colour in (en=1) or out (en=0).
module sat_restore #(
  parameter int unsigned GAIN_W          = 4,
  parameter int unsigned STEP            = 1,
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              frame_start,
  input  logic [23:0]       pixel_in,
  output logic [23:0]       pixel_out,
  input  logic [23:0]       pass_in,
  output logic [23:0]       pass_thru,
  output logic [GAIN_W:0]   gain,
  output logic              busy
);

  localparam int unsigned CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned PW = 7 + GAIN_W + 1;

  localparam logic [GAIN_W+1:0] FULL_X = (GAIN_W + 2)'(2 ** GAIN_W);
  localparam logic [GAIN_W+1:0] STEP_X = (GAIN_W + 2)'(STEP);
  localparam logic [GAIN_W:0]   FULL_G = FULL_X[GAIN_W:0];
  localparam logic [CW-1:0]     WRAP   = CW'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {
    GRAY      = 2'd0,
    RAMP_UP   = 2'd1,
    COLOR     = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [GAIN_W:0] gain_nx;
  logic [GAIN_W:0] gain_up, gain_dn;
  logic [GAIN_W+1:0] gain_sum;
  logic            step_due;
  logic [PW-1:0]   prod;
  logic [6:0]      sat_scaled;

  // Saturating step values, computed one bit wider so gain+STEP cannot wrap.
  always_comb begin
    gain_sum = {1'b0, gain} + STEP_X;
    gain_up  = (gain_sum > FULL_X) ? FULL_G : gain_sum[GAIN_W:0];
    gain_dn  = ({1'b0, gain} > STEP_X) ? (gain - STEP_X[GAIN_W:0]) : '0;
    step_due = frame_start && (cnt == WRAP);
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gain_nx  = gain;
    case (state)
      GRAY: begin
        if (en) begin
          state_nx = RAMP_UP;
          cnt_nx   = '0;
        end
      end
      RAMP_UP: begin
        if (!en) begin
          state_nx = RAMP_DOWN;
          cnt_nx   = '0;
        end else if (frame_start) begin
          if (step_due) begin
            cnt_nx  = '0;
            gain_nx = gain_up;
            if (gain_up == FULL_G) state_nx = COLOR;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      COLOR: begin
        if (!en) begin
          state_nx = RAMP_DOWN;
          cnt_nx   = '0;
        end
      end
      RAMP_DOWN: begin
        if (en) begin
          state_nx = RAMP_UP;
          cnt_nx   = '0;
        end else if (frame_start) begin
          if (step_due) begin
            cnt_nx  = '0;
            gain_nx = gain_dn;
            if (gain_dn == '0) state_nx = GRAY;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nx = GRAY;
        cnt_nx   = '0;
        gain_nx  = '0;
      end
    endcase
  end

  always_comb begin
    prod       = PW'(pixel_in[14:8]) * PW'(gain);
    sat_scaled = 7'(prod >> GAIN_W);
    busy       = (state == RAMP_UP) || (state == RAMP_DOWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= GRAY;
      cnt       <= '0;
      gain      <= '0;
      pixel_out <= '0;
      pass_thru <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      gain      <= gain_nx;
      pixel_out <= {pixel_in[23:15], sat_scaled, pixel_in[7:0]};
      pass_thru <= pass_in;
    end
  end

endmodule

// File: tb/tb_sat_restore.sv
// Scoreboard bench for sat_restore: a driver pushes model-predicted responses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_sat_restore;

  localparam int GW   = 4;
  localparam int FULL = 16;
  localparam int STP  = 1;
  localparam int FPS  = 2;

  logic          clk = 1'b0;
  logic          rst, en, frame_start;
  logic [23:0]   pixel_in, pass_in;
  logic [23:0]   pixel_out, pass_thru;
  logic [GW:0]   gain;
  logic          busy;

  sat_restore #(
    .GAIN_W(GW),
    .STEP(STP),
    .FRAMES_PER_STEP(FPS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .frame_start(frame_start),
    .pixel_in(pixel_in),
    .pixel_out(pixel_out),
    .pass_in(pass_in),
    .pass_thru(pass_thru),
    .gain(gain),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [23:0] pix;
    logic [23:0] pas;
    logic [GW:0] g;
    logic        b;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: gain level, direction of travel, ramping flag, strobe count.
  int   m_gain = 0;
  int   m_cnt  = 0;
  bit   m_up   = 1'b0;
  bit   m_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t x;
    while (q.size() > 0 && q[0].due <= cyc) begin
      x = q.pop_front();
      n_cmp++;
      if (x.due != cyc || pixel_out !== x.pix || pass_thru !== x.pas ||
          gain !== x.g || busy !== x.b) begin
        n_bad++;
        $display("FAIL sb cyc=%0d: got pix=%h pass=%h gain=%0d busy=%b, want pix=%h pass=%h gain=%0d busy=%b",
                 cyc, pixel_out, pass_thru, gain, busy, x.pix, x.pas, x.g, x.b);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp_v);
    end
  endtask

  function automatic logic [23:0] pix_sat(input int s);
    return {9'($urandom), 7'(s), 8'($urandom)};
  endfunction

  task automatic drive(input bit r, input bit e, input bit f,
                       input logic [23:0] p, input logic [23:0] ps);
    exp_t x;
    int   s;
    rst = r; en = e; frame_start = f; pixel_in = p; pass_in = ps;
    x.due = cyc + 1;
    if (r) begin
      x.pix = '0; x.pas = '0;
      m_gain = 0; m_cnt = 0; m_up = 1'b0; m_busy = 1'b0;
    end else begin
      s = int'(p[14:8]);
      x.pix = {p[23:15], 7'(s * m_gain / FULL), p[7:0]};
      x.pas = ps;
      if (e != m_up) begin
        m_up = e; m_busy = 1'b1; m_cnt = 0;
      end else if (m_busy && f) begin
        m_cnt++;
        if (m_cnt == FPS) begin
          m_cnt = 0;
          if (m_up) m_gain = (m_gain + STP > FULL) ? FULL : m_gain + STP;
          else      m_gain = (m_gain - STP < 0) ? 0 : m_gain - STP;
          if (m_gain == (m_up ? FULL : 0)) m_busy = 1'b0;
        end
      end
    end
    x.g = (GW+1)'(m_gain);
    x.b = m_busy;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input int n, input bit e, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < gap - 1; j++) drive(1'b0, e, 1'b0, 24'($urandom), 24'($urandom));
      drive(1'b0, e, 1'b1, 24'($urandom), 24'($urandom));
    end
  endtask

  initial begin
    logic [23:0] ps;
    bit          re;
    rst = 1'b1; en = 1'b0; frame_start = 1'b0; pixel_in = '0; pass_in = '0;
    @(posedge clk);
    #1;

    // Reset and idle gray
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 24'($urandom), 24'($urandom));
    chk("rst_gain", int'(gain), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pix", int'(pixel_out), 0);
    ps = '0;
    for (int i = 0; i < 10; i++) begin
      ps = 24'($urandom);
      drive(1'b0, 1'b0, 1'b0, 24'h1F6480, ps);
    end
    chk("gray_pix", int'(pixel_out), 32'h1F0080);
    chk("gray_pass", int'(pass_thru), int'(ps));
    chk("gray_gain", int'(gain), 0);

    // Ramp up
    strobes(2, 1'b1, 100);
    chk("up_gain1", int'(gain), 1);
    drive(1'b0, 1'b1, 1'b0, pix_sat(127), 24'($urandom));
    chk("sat127_g1", int'(pixel_out[14:8]), 7);
    strobes(14, 1'b1, 100);
    chk("up_gain8", int'(gain), 8);
    chk("up_busy", int'(busy), 1);
    drive(1'b0, 1'b1, 1'b0, pix_sat(100), 24'($urandom));
    chk("sat100_g8", int'(pixel_out[14:8]), 50);
    strobes(16, 1'b1, 100);
    chk("up_full", int'(gain), 16);
    chk("color_busy", int'(busy), 0);
    drive(1'b0, 1'b1, 1'b0, pix_sat(127), 24'($urandom));
    chk("sat127_g16", int'(pixel_out[14:8]), 127);

    // Ramp down
    drive(1'b0, 1'b0, 1'b0, 24'($urandom), 24'($urandom));
    chk("down_busy", int'(busy), 1);
    strobes(32, 1'b0, 100);
    chk("down_gain0", int'(gain), 0);
    chk("gray_busy", int'(busy), 0);

    // Reversal coinciding with a strobe
    strobes(10, 1'b1, 20);
    chk("rev_gain5", int'(gain), 5);
    drive(1'b0, 1'b0, 1'b1, 24'($urandom), 24'($urandom));
    chk("rev_hold", int'(gain), 5);
    chk("rev_busy", int'(busy), 1);
    strobes(1, 1'b0, 10);
    chk("rev_nostep", int'(gain), 5);
    strobes(1, 1'b0, 10);
    chk("rev_gain4", int'(gain), 4);

    // Reset mid-ramp
    strobes(10, 1'b1, 10);
    chk("pre_rst_gain9", int'(gain), 9);
    drive(1'b1, 1'b1, 1'b0, 24'($urandom), 24'($urandom));
    chk("mid_rst_gain", int'(gain), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_pix", int'(pixel_out), 0);
    chk("mid_rst_pass", int'(pass_thru), 0);
    strobes(4, 1'b0, 5);
    chk("gray_fs_gain", int'(gain), 0);
    chk("gray_fs_busy", int'(busy), 0);

    // Saturation sweep at gain 12
    strobes(24, 1'b1, 4);
    chk("hold_gain12", int'(gain), 12);
    for (int s = 0; s < 128; s++) begin
      drive(1'b0, 1'b1, 1'b0, pix_sat(s), 24'($urandom));
      chk("sweep_g12", int'(pixel_out[14:8]), (s * 12) / 16);
    end

    // Random traffic
    re = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) re = ~re;
      drive(($urandom_range(0, 499) == 0), re, ($urandom_range(0, 7) == 0),
            24'($urandom), 24'($urandom));
    end

    drive(1'b0, re, 1'b0, 24'($urandom), 24'($urandom));
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
